serial_frame_tx: RTL and testbench

// - Serial-line transmitter: takes one parallel byte per valid/ready handshake and shifts it out as an asynchronous frame.
// - Frame format: start bit (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
// - Sits between the parallel TX latch path and the off-chip serial line. It is the sending end that the serial receive path samples.

---
 rtl/serial_frame_tx_pkg.sv | 28 ++
 rtl/serial_frame_tx_baud_tick_gen.sv | 37 +++
 rtl/serial_frame_tx.sv | 138 +++++++++++++
 tb/tb_serial_frame_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding and
// line levels, plus a helper that maps a state to the level it drives.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    function automatic logic line_level(input state_t st, input logic data_bit,
                                        input logic parity_bit);
        logic lvl;
        case (st)
            ST_START:  lvl = LINE_START;
            ST_DATA:   lvl = data_bit;
            ST_PARITY: lvl = parity_bit;
            default:   lvl = LINE_IDLE;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/serial_frame_tx_baud_tick_gen.sv
// Free-running bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses tick
// on the last count; clear holds it at zero.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = ~clear & (count_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Asynchronous serial frame transmitter: start bit, DATA_W data bits LSB first,
// optional parity bit, STOP_BITS stop bits. One byte per valid/ready handshake.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept;
    logic tick;
    logic baud_clear;

    assign accept     = tx_valid & tx_ready_q;
    assign baud_clear = (state_q == ST_IDLE);

    // Held in clear while idle so the first bit of a frame gets a full period.
    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    parity_d  = (^tx_data) ^ 1'(PARITY_ODD);
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register cleanly.
        tx_line_d  = line_level(state_d, shift_d[0], parity_d);
        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = ~tx_ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_line_q  <= LINE_IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_line_q  <= tx_line_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_line  = tx_line_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed-plus-random bench for serial_frame_tx across four parameter sets,
// checked cycle by cycle against a frame model built from the line format.
module tb_serial_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst;
    logic [3:0] tx_valid;
    logic [3:0] tx_ready;
    logic [3:0] tx_line;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] tx_data [4];

    int errors = 0;
    int checks = 0;

    // Per-instance configuration: clks/bit, parity enable, odd parity, stop bits
    int cpb   [4] = '{4, 4, 4, 7};
    int pen   [4] = '{1, 1, 0, 1};
    int podd  [4] = '{0, 1, 0, 0};
    int stops [4] = '{1, 1, 1, 2};

    bit exp_bits[$];

    serial_frame_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_line(tx_line[0]), .busy(busy[0]), .done(done[0]));
    serial_frame_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_line(tx_line[1]), .busy(busy[1]), .done(done[1]));
    serial_frame_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx_line(tx_line[2]), .busy(busy[2]), .done(done[2]));
    serial_frame_tx #(.CLKS_PER_BIT(7), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst[3]), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .tx_line(tx_line[3]), .busy(busy[3]), .done(done[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends d on instance k and checks every cycle of the frame. With pre=1 the
    // accept edge has already happened; with keep=1 tx_valid stays high and
    // tx_data switches to nd, so the next frame is accepted on the done cycle.
    task automatic frame(input int k, input logic [7:0] d, input bit pre,
                         input bit keep, input logic [7:0] nd);
        int ones;
        int len;
        int bcnt;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen[k] == 1) exp_bits.push_back(((ones % 2) == 1) ^ (podd[k] == 1));
        for (int s = 0; s < stops[k]; s++) exp_bits.push_back(1'b1);
        len = cpb[k] * exp_bits.size();

        if (!pre) begin
            tx_valid[k] = 1'b1;
            tx_data[k]  = d;
            @(negedge clk);
            chk($sformatf("k%0d idle_done", k), done[k], 0);
            chk($sformatf("k%0d ready_pre", k), tx_ready[k], 1);
            chk($sformatf("k%0d line_idle", k), tx_line[k], 1);
            @(posedge clk);
            #1;
        end
        tx_data[k]  = nd;
        tx_valid[k] = keep;

        bcnt = 0;
        foreach (exp_bits[b]) begin
            for (int c = 0; c < cpb[k]; c++) begin
                @(negedge clk);
                chk($sformatf("k%0d line b%0d c%0d", k, b, c), tx_line[k], exp_bits[b]);
                chk($sformatf("k%0d ready_low b%0d", k, b), tx_ready[k], 0);
                chk($sformatf("k%0d done_low b%0d", k, b), done[k], 0);
                if (busy[k] === 1'b1) bcnt++;
            end
        end
        chk($sformatf("k%0d busy_len", k), bcnt, len);

        @(negedge clk);
        chk($sformatf("k%0d done_pulse", k), done[k], 1);
        chk($sformatf("k%0d ready_after", k), tx_ready[k], 1);
        chk($sformatf("k%0d busy_after", k), busy[k], 0);
        chk($sformatf("k%0d line_after", k), tx_line[k], 1);
        $display("frame k=%0d data=0x%02h bits=%0d cycles=%0d errors=%0d", k, d, exp_bits.size(), len, errors);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        rst      = '1;
        tx_valid = '0;
        for (int k = 0; k < 4; k++) tx_data[k] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("k%0d rst_line", k), tx_line[k], 1);
            chk($sformatf("k%0d rst_ready", k), tx_ready[k], 1);
            chk($sformatf("k%0d rst_busy", k), busy[k], 0);
            chk($sformatf("k%0d rst_done", k), done[k], 0);
        end
        $display("reset released");
        rst = '0;

        frame(0, 8'hA5, 0, 0, 8'($urandom));
        frame(1, 8'h01, 0, 0, 8'($urandom));
        frame(2, 8'hFF, 0, 0, 8'($urandom));
        frame(3, 8'h00, 0, 0, 8'($urandom));

        // Back-to-back with tx_valid held high across the done cycle
        frame(0, 8'h3C, 0, 1, 8'hC3);
        frame(0, 8'hC3, 1, 0, 8'($urandom));

        // Data changes right after accept must not disturb the frame
        frame(0, 8'h5A, 0, 0, 8'h00);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                frame(k, 8'($urandom), 0, 0, 8'($urandom));
            end
        end

        // Abort during data bit 3
        d           = 8'($urandom);
        tx_valid[0] = 1'b1;
        tx_data[0]  = d;
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("abort bit3", tx_line[0], d[3]);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort line", tx_line[0], 1);
        chk("abort ready", tx_ready[0], 1);
        chk("abort busy", busy[0], 0);
        chk("abort done", done[0], 0);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            chk($sformatf("abort quiet done c%0d", i), done[0], 0);
            chk($sformatf("abort quiet line c%0d", i), tx_line[0], 1);
        end
        $display("abort k=0 data=0x%02h errors=%0d", d, errors);
        @(posedge clk);
        #1;
        frame(0, 8'h81, 0, 0, 8'($urandom));

        // Reset and valid at the same edge: the byte must not be taken
        rst[2]      = 1'b1;
        tx_valid[2] = 1'b1;
        tx_data[2]  = 8'h55;
        @(posedge clk);
        #1;
        rst[2]      = 1'b0;
        tx_valid[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rst_valid line c%0d", i), tx_line[2], 1);
            chk($sformatf("rst_valid busy c%0d", i), busy[2], 0);
            chk($sformatf("rst_valid ready c%0d", i), tx_ready[2], 1);
        end
        $display("reset_with_valid k=2 errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
